// File: rtl/dpi_bus_slave_mem.sv
module dpi_bus_slave_mem #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [CNT_W-1:0]    txn_count
);

  localparam int unsigned     STRB_W    = DATA_W / 8;
  localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  txn_count_q, txn_count_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] merged;
  logic              mem_we;

  assign idx       = addr_q[IDX_W-1:0];
  assign in_range  = ({1'b0, addr_q} < DEPTH_L);
  assign mem_rd    = mem[idx];
  assign mem_we    = (state_q == S_COMMIT) && in_range && write_q;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_count_q;

  always_comb begin
    merged = mem_rd;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wstrb_q[i]) begin
        merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_COMMIT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_COMMIT: begin
        rsp_valid_d = 1'b1;
        txn_count_d = txn_count_q + CNT_W'(1);
        if (!in_range) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? '0 : mem_rd;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Memory is not reset; async reset forces state_q out of S_COMMIT.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dpi_bus_slave_mem.sv
// Self-checking bench for dpi_bus_slave_mem (DEPTH=200, WAIT_CYCLES=2,
// CNT_W=2, DATA_W=32). A transaction-level model predicts the outputs and
// is compared against the DUT on every falling edge; directed transactions
// carry hand-computed expected values.
module tb_dpi_bus_slave_mem;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 200;
    localparam int WAITC  = 2;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [CNT_W-1:0]  txn_count;

    always #5 clk = ~clk;

    dpi_bus_slave_mem #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .txn_count (txn_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit [31:0] mm [DEPTH];
    bit        m_busy, m_resp;
    int        m_age;
    bit        p_w;
    bit [7:0]  p_a;
    bit [31:0] p_d;
    bit [3:0]  p_s;
    bit        exp_valid, exp_err;
    bit [31:0] exp_rdata;
    int        exp_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_resp = 0; m_age = 0;
            exp_valid = 0; exp_err = 0; exp_rdata = 0; exp_count = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_age = 0;
                p_w = req_write; p_a = req_addr; p_d = req_wdata; p_s = req_wstrb;
            end
        end else if (!m_resp) begin
            m_age++;
            if (m_age == WAITC + 1) begin
                bit [31:0] mask;
                m_resp    = 1;
                exp_valid = 1;
                exp_count = (exp_count + 1) % (1 << CNT_W);
                if (p_a >= DEPTH) begin
                    exp_err = 1; exp_rdata = 0;
                end else if (p_w) begin
                    mask = 0;
                    for (int b = 0; b < 4; b++)
                        if (p_s[b]) mask = mask | (32'hFF << (8 * b));
                    mm[p_a] = (mm[p_a] & ~mask) | (p_d & mask);
                    exp_err = 0; exp_rdata = 0;
                end else begin
                    exp_err = 0; exp_rdata = mm[p_a];
                end
            end
        end else if (rsp_ready) begin
            m_busy = 0; m_resp = 0;
            exp_valid = 0; exp_err = 0; exp_rdata = 0;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("model_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            chk("model_rsp_rdata", rsp_rdata, exp_rdata);
            chk("model_rsp_err",   {31'd0, rsp_err}, {31'd0, exp_err});
            chk("model_txn_count", {30'd0, txn_count}, 32'(exp_count));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the request bus: it must only be sampled at acceptance.
        req_valid = 0;
        req_write = ~w;
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    task automatic collect(input int hold, output logic [31:0] rd, output logic er,
                           output logic [1:0] cnt, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata; er = rsp_err; cnt = txn_count;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            rsp_ready = 1;
        end
        @(posedge clk);
        #1;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic txn(input string nm, input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] e_rd, input bit e_er,
                       input logic [1:0] e_cnt);
        logic [31:0] rd;
        logic        er;
        logic [1:0]  cnt;
        int          lat;
        send(w, a, d, s);
        collect(0, rd, er, cnt, lat);
        chk({nm, "_lat"},   32'(lat), 32'd3);
        chk({nm, "_rdata"}, rd, e_rd);
        chk({nm, "_err"},   {31'd0, er}, {31'd0, e_er});
        chk({nm, "_cnt"},   {30'd0, cnt}, {30'd0, e_cnt});
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
        chk({nm, "_txn_count"}, {30'd0, txn_count}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  cnt;
        int          lat;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        #2;
        rst = 0;
        cmp_en = 1;

        // Full-word write then read back.
        txn("wr10",  1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        0, 2'd1);
        txn("rd10",  0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, 2'd2);

        // Byte-strobe merge.
        txn("wr5a",  1, 8'h05, 32'h11223344, 4'hF, 32'h0,        0, 2'd3);
        txn("wr5b",  1, 8'h05, 32'hAABBCCDD, 4'h5, 32'h0,        0, 2'd0);
        txn("rd5",   0, 8'h05, 32'h0,        4'hF, 32'h11BB33DD, 0, 2'd1);

        // Out-of-range accesses must not alias onto 0xF0-200 = 40.
        txn("wr40",  1, 8'd40, 32'hCAFEF00D, 4'hF, 32'h0,        0, 2'd2);
        txn("rdF0",  0, 8'hF0, 32'h0,        4'hF, 32'h0,        1, 2'd3);
        txn("wrF0",  1, 8'hF0, 32'hFFFFFFFF, 4'hF, 32'h0,        1, 2'd0);
        txn("rd40",  0, 8'd40, 32'h0,        4'hF, 32'hCAFEF00D, 0, 2'd1);

        // Response back-pressure with a second request waiting.
        rsp_ready = 0;
        send(0, 8'h10, 32'h0, 4'h0);
        req_valid = 1; req_write = 1; req_addr = 8'h07; req_wdata = 32'h00000077; req_wstrb = 4'hF;
        collect(5, rd, er, cnt, lat);
        chk("hold_lat",   32'(lat), 32'd3);
        chk("hold_rdata", rd, 32'hDEADBEEF);
        chk("hold_err",   {31'd0, er}, 32'd0);
        chk("hold_cnt",   {30'd0, cnt}, 32'd2);
        chk("hold_req_ready_after_hs", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 0;
        chk("hold_second_accepted", {31'd0, req_ready}, 32'd0);
        collect(0, rd, er, cnt, lat);
        chk("second_lat", 32'(lat), 32'd3);
        chk("second_err", {31'd0, er}, 32'd0);
        chk("second_cnt", {30'd0, cnt}, 32'd3);

        // Reset during WAIT discards the write.
        txn("wr3z",  1, 8'h03, 32'h0, 4'hF, 32'h0, 0, 2'd0);
        send(1, 8'h03, 32'h12345678, 4'hF);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        reset_checks("midrst");
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 0;

        // Counter wrap 1,2,3,0,1; wstrb=0 write still commits.
        txn("rd3",   0, 8'h03, 32'h0,        4'hF, 32'h0,        0, 2'd1);
        txn("wr5s0", 1, 8'h05, 32'hFFFFFFFF, 4'h0, 32'h0,        0, 2'd2);
        txn("rd5b",  0, 8'h05, 32'h0,        4'hF, 32'h11BB33DD, 0, 2'd3);
        txn("rd10b", 0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF, 0, 2'd0);
        txn("rd7",   0, 8'h07, 32'h0,        4'hF, 32'h00000077, 0, 2'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpi_bus_slave_mem.md
Name: dpi_bus_slave_mem

Overview:
- Parametrised successor to the simple write-only DPI bus slave.
- Memory-backed bus slave with read and write, byte strobes, programmable wait states, out-of-range error response and a transaction counter.
- Valid/ready request and response channels.
- Sits behind the testbench bus master as the RTL replacement for the C-side buffer.
- Can optionally mirror every committed transaction to C over DPI.

Parameters:
- ADDR_W, 8, request address width in words.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 256, number of memory words; 1 <= DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2, idle cycles inserted between acceptance and commit; 0..15.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  slave can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables for a write.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.
- txn_count  out  CNT_W  number of committed transactions.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, txn_count = 0, wait counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, COMMIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch write, addr, wdata and wstrb.
  - Go to WAIT with counter = WAIT_CYCLES-1, or to COMMIT if WAIT_CYCLES == 0.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle; go to COMMIT when the counter is 0.
- COMMIT (one cycle, req_ready = 0):
  - If addr < DEPTH and write: for each byte i with wstrb[i] = 1, update mem byte i; bytes with wstrb[i] = 0 are unchanged.
  - If addr < DEPTH and read: rsp_rdata = mem[addr], taking the value before any same-cycle update (none is possible).
  - If addr >= DEPTH: no memory access, rsp_err = 1, rsp_rdata = 0.
  - txn_count increments, wrapping to 0 at 2**CNT_W. Errored transactions count.
  - Set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that cycle: clear rsp_valid, rsp_err and rsp_rdata, and return to IDLE.
  - req_ready returns to 1 the cycle after the handshake. No request overlap: at most one transaction in flight.
- Latency: rsp_valid rises WAIT_CYCLES+1 clock edges after the acceptance edge. Throughput is one transaction per WAIT_CYCLES+3 cycles with rsp_ready held at 1.
- req_wstrb is ignored for reads. A write with wstrb = 0 still commits, counts and responds with err = 0.
- Request inputs are sampled only on the acceptance edge; changes afterwards have no effect.
- Reset during WAIT: the transaction is discarded with no memory write and no count.
- Reset during RESP: the response is dropped and the already-committed write persists.

Optional Feature:
- Macro: DPI_BUS_TRACE_EN.
- Defined:
  - The module imports DPI-C function void bus_trace(input int is_write, input int addr, input int data, input int err).
  - It calls bus_trace once in the COMMIT cycle of every transaction.
  - data is the masked wdata for writes and the read data for reads.
  - The call takes zero simulation time; zero-extend or truncate data to 32 bits.
- Undefined: no import or call is present, the block is pure synthesizable RTL, and port behaviour is identical.

Test Plan (DEPTH=256, WAIT_CYCLES=2, DATA_W=32):
- Write addr 0x10 data 0xDEADBEEF wstrb 0xF, then read 0x10 -> rdata 0xDEADBEEF, err 0; rsp_valid 3 edges after each acceptance; txn_count = 2.
- Write 0x11223344 to addr 5, then write 0xAABBCCDD to addr 5 with wstrb 0x5, then read addr 5 -> 0x11BB33DD.
- DEPTH=200, read addr 0xF0 -> err 1, rdata 0; write addr 0xF0 -> err 1, and no alias corruption at addr 0xF0-200.
- Hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stable, req_ready = 0, and a second req_valid is not accepted until 1 cycle after the handshake.
- Assert rst in WAIT of a write to addr 3 (previously 0x0) -> outputs return to reset values at once, addr 3 still reads 0x0, txn_count = 0.
- CNT_W=2: issue 5 transactions -> txn_count sequence 1, 2, 3, 0, 1. With DPI_BUS_TRACE_EN, the C side logs exactly 5 calls with matching fields.
